// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (IF) and LSU with req/ack handshakes
// Optional MEM_ARB_ROUND_ROBIN_EN: simultaneous requests go to the requester that did not own the last access.
module mem_port_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int XLEN         = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_ack,
    output logic [XLEN-1:0] o_if_rdata,
    input  logic            i_lsu_req,
    input  logic            i_lsu_we,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_ack,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_wenable,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_busy,
    output logic            o_grant_lsu
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t     r_state, w_state_nxt;
    logic       r_grant_lsu, w_grant_nxt;
    logic       r_is_write, w_is_write_nxt;
    logic [2:0] r_count, w_count_nxt;
    logic       w_pick_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the LSU wins only if IF owned the previous access.
    assign w_pick_lsu = i_lsu_req && (!i_if_req || !r_grant_lsu);
`else
    assign w_pick_lsu = i_lsu_req;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_grant_lsu <= 1'b0;
            r_is_write  <= 1'b0;
            r_count     <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_lsu <= w_grant_nxt;
            r_is_write  <= w_is_write_nxt;
            r_count     <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant_lsu;
        w_is_write_nxt = r_is_write;
        w_count_nxt    = r_count;
        o_busy         = 1'b0;
        o_if_ack       = 1'b0;
        o_lsu_ack      = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_mem_wenable  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_if_req || i_lsu_req) begin
                    w_state_nxt    = BUSY;
                    w_grant_nxt    = w_pick_lsu;
                    w_is_write_nxt = w_pick_lsu && i_lsu_we;
                    w_count_nxt    = (w_pick_lsu && i_lsu_we) ? 3'd0 : LAT;
                end
            end
            BUSY: begin
                o_busy        = 1'b1;
                o_mem_addr    = r_grant_lsu ? i_lsu_addr : i_if_addr;
                o_mem_wdata   = r_grant_lsu ? i_lsu_wdata : '0;
                // Writes start with count 0, so the strobe is confined to the first BUSY cycle.
                o_mem_wenable = r_is_write && (r_count == 3'd0);
                if (r_count != 3'd0) begin
                    w_count_nxt = r_count - 3'd1;
                end else begin
                    o_if_ack    = !r_grant_lsu;
                    o_lsu_ack   = r_grant_lsu;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_if_rdata  = i_mem_rdata;
    assign o_lsu_rdata = i_mem_rdata;
    assign o_grant_lsu = r_grant_lsu;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] if_addr = '0, lsu_addr = '0, lsu_wdata = '0, mem_rdata = '0;
    logic        if_ack, lsu_ack, mem_wenable, busy, grant_lsu;
    logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.READ_LATENCY(2), .XLEN(32)) dut (
        .i_clock(clock), .i_reset(reset),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
        .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
        .o_lsu_ack(lsu_ack), .o_lsu_rdata(lsu_rdata),
        .o_mem_addr(mem_addr), .o_mem_wenable(mem_wenable), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy), .o_grant_lsu(grant_lsu)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic e_busy, input logic e_if_ack,
                              input logic e_lsu_ack, input logic [31:0] e_addr, input logic e_wen);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        check({tag, ".if_ack"}, {31'd0, if_ack}, {31'd0, e_if_ack});
        check({tag, ".lsu_ack"}, {31'd0, lsu_ack}, {31'd0, e_lsu_ack});
        check({tag, ".mem_addr"}, mem_addr, e_addr);
        check({tag, ".mem_wen"}, {31'd0, mem_wenable}, {31'd0, e_wen});
    endtask

    logic        first_lsu;
    logic [31:0] a1, a2;

    initial begin
        // Reset state
        settle();
        expect_cyc("rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst.wdata", mem_wdata, 32'h0);
        check("rst.grant", {31'd0, grant_lsu}, 32'h0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_cyc($sformatf("idle%0d", c), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        // IF read, READ_LATENCY=2
        step();
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h00072603;
        settle();
        expect_cyc("rd.c0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_cyc($sformatf("rd.c%0d", c), 1'b1, (c == 3), 1'b0, 32'h100, 1'b0);
            check($sformatf("rd.grant%0d", c), {31'd0, grant_lsu}, 32'h0);
        end
        check("rd.if_rdata", if_rdata, 32'h00072603);
        step();
        if_req = 1'b0;
        settle();
        expect_cyc("rd.c4", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // LSU store: single-cycle write
        step();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'hCAFEBABE;
        settle();
        expect_cyc("wr.c0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        expect_cyc("wr.c1", 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
        check("wr.wdata", mem_wdata, 32'hCAFEBABE);
        check("wr.grant", {31'd0, grant_lsu}, 32'h1);
        step();
        lsu_req = 1'b0; lsu_we = 1'b0;
        settle();
        expect_cyc("wr.c2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Simultaneous requests; last owner was the LSU
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif
        a1 = first_lsu ? 32'h300 : 32'h104;
        a2 = first_lsu ? 32'h104 : 32'h300;
        step();
        if_req = 1'b1; if_addr = 32'h104;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300; lsu_wdata = 32'h0;
        mem_rdata = 32'h12345678;
        settle();
        expect_cyc("both.c0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_cyc($sformatf("both.c%0d", c), 1'b1, !first_lsu && c == 3,
                       first_lsu && c == 3, a1, 1'b0);
        end
        check("both.rdata1", first_lsu ? lsu_rdata : if_rdata, 32'h12345678);
        step();
        if (first_lsu) lsu_req = 1'b0; else if_req = 1'b0;
        mem_rdata = 32'h0BADF00D;
        settle();
        expect_cyc("both.c4", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 5; c <= 7; c++) begin
            step();
            expect_cyc($sformatf("both.c%0d", c), 1'b1, first_lsu && c == 7,
                       !first_lsu && c == 7, a2, 1'b0);
        end
        check("both.rdata2", first_lsu ? if_rdata : lsu_rdata, 32'h0BADF00D);
        step();
        if_req = 1'b0; lsu_req = 1'b0;
        settle();
        expect_cyc("both.c8", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of an IF read, then a clean read
        step();
        if_req = 1'b1; if_addr = 32'h108;
        step();
        expect_cyc("mr.c1", 1'b1, 1'b0, 1'b0, 32'h108, 1'b0);
        step();
        reset = 1'b1;
        settle();
        expect_cyc("mr.c2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        settle();
        expect_cyc("mr.c3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 4; c <= 6; c++) begin
            step();
            expect_cyc($sformatf("mr.c%0d", c), 1'b1, (c == 6), 1'b0, 32'h108, 1'b0);
        end
        step();
        if_req = 1'b0;
        settle();
        expect_cyc("mr.c7", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the hart's single memory port between instruction fetch (IF) and the load/store unit (LSU).
- Serializes requests and holds each grant for the full access: fixed-latency reads, single-cycle writes.
- Routes the completion acknowledgement back to the owning requester.
- Sits between the fetch/memory stages and the memory; the stages see a simple req/ack handshake instead of counting latency themselves.

Parameters:
- READ_LATENCY, 2, cycles from address presented to valid mem_rdata (1..7).
- XLEN, 32, address/data width (from isa_types).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  XLEN  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid this cycle
- if_rdata  out  XLEN  fetched word
- lsu_req  in  1  LSU request; held until lsu_ack
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  XLEN  LSU address; stable while lsu_req
- lsu_wdata  in  XLEN  store data
- lsu_ack  out  1  one-cycle pulse: LSU access done
- lsu_rdata  out  XLEN  load data
- mem_addr  out  XLEN  memory address
- mem_wenable  out  1  memory write strobe
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data
- busy  out  1  transaction in progress
- grant_lsu  out  1  current/last owner: 1 = LSU, 0 = IF

Behaviour:
- States: IDLE, BUSY. Registers: state, grant_lsu, is_write, count (3 bits).
- Reset (async): state = IDLE, grant_lsu = 0, count = 0, is_write = 0.
- Reset output values: if_ack = lsu_ack = 0, mem_wenable = 0, busy = 0, mem_addr = 0, mem_wdata = 0.
- IDLE, no req: stay in IDLE; outputs at reset values.
- IDLE, any req: next state BUSY.
  - Winner selection: lsu_req beats if_req (fixed priority).
  - grant_lsu is latched to the winner.
  - is_write = lsu_we when LSU wins, else 0.
  - count = 0 for a write, READ_LATENCY for a read.
- No ack and no memory activity in the IDLE cycle. A request raised at cycle N enters BUSY at N+1.
- BUSY:
  - busy = 1.
  - mem_addr = addr of the granted requester.
  - mem_wdata = lsu_wdata when LSU is granted, else 0.
  - mem_wenable = is_write, asserted only in the first BUSY cycle (count == 0 with is_write).
  - count != 0: decrement by 1 and stay in BUSY.
  - count == 0: pulse the granted requester's ack (combinational, this cycle) and return to IDLE next cycle.
- Latency:
  - Read: req at N, ack at N+1+READ_LATENCY.
  - Write: ack at N+1.
- Read data: if_rdata and lsu_rdata both pass mem_rdata through; each is valid only in its own ack cycle.
- Back-to-back: the IDLE cycle after every ack is mandatory (one bubble). Requesters deassert req on the clock edge after ack.
- Mid-transaction req drop: not an abort. The access completes and ack still pulses. Address/data are sampled live, so requesters must hold them stable.
- Simultaneous requests in IDLE: LSU wins. IF stays pending and is granted in the following IDLE cycle if lsu_req is low.
- At most one ack is high in any cycle; never both.
- Reset mid-transaction: immediate return to IDLE; any pending ack is dropped; mem_wenable = 0 at once.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the winner is the requester NOT named by grant_lsu (the last owner). A single requester is always granted.
- Undefined: fixed LSU priority as above; IF may starve under continuous LSU traffic, which is acceptable because the LSU issues at most one access per instruction.

Test Plan:
- Reset → all outputs 0; with no requests, stays idle for 3 cycles.
- READ_LATENCY=2, if_req with if_addr=0x100 at cycle 0, mem_rdata=0x00072603 → mem_addr=0x100 for cycles 1–3; if_ack pulses at cycle 3 with if_rdata=0x00072603; busy=0 at cycle 4.
- lsu_req, lsu_we=1, lsu_addr=0x200, lsu_wdata=0xCAFEBABE at cycle 0 → mem_wenable=1 at cycle 1 only; lsu_ack at cycle 1.
- if_req and lsu_req (load, 0x300) both at cycle 0:
  - without macro: lsu_ack at cycle 3, if_ack at cycle 7;
  - with MEM_ARB_ROUND_ROBIN_EN after an LSU-granted transaction: IF is served first.
- Reset asserted at cycle 2 of an IF read → if_ack never pulses, busy drops immediately; after release, a new IF read completes with normal latency.
